spi_key_loader: RTL and testbench

//  Parametrised serial key loader for the cipher datapath. Deserialises NUM_KEYS round keys of KEY_WIDTH bits

---
 rtl/spi_key_loader.sv | 183 ++++++++++++++++++
 tb/tb_spi_key_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_key_loader.sv
// spi_key_loader: loads NUM_KEYS round keys of KEY_WIDTH bits each into a key file.
// The keys arrive on asynchronous SPI-style pins (spi_clk, spi_serial, spi_cs_n).
// All three pins are synchronised into clk before use. The key file is read
// through a registered port.
//
// Handshake: there is no valid/ready pair on this block. key_wr is a one-cycle
// strobe with key_wr_idx valid in that same cycle. It rises on the same edge that
// writes the key file, and the consumer may not stall it.
module spi_key_loader #(
  parameter int KEY_WIDTH   = 48,
  parameter int NUM_KEYS    = 16,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = $clog2(NUM_KEYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_clk,
  input  logic                 spi_serial,
  input  logic                 spi_cs_n,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [KEY_WIDTH-1:0] rd_key,
  output logic                 key_wr,
  output logic [IDX_W-1:0]     key_wr_idx,
  output logic                 keys_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CNT_W      = $clog2(KEY_WIDTH + 1);
  // The file is sized to the full index range. Entries at or above NUM_KEYS are
  // never written, so they read back as zero without an explicit range compare.
  localparam int FILE_DEPTH = 1 << IDX_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdat_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic                   sclk_s;
  logic                   sdat_s;
  logic                   cs_s;
  logic                   rise;
  logic                   cs_fall;

  logic [1:0]             state;
  logic [KEY_WIDTH-1:0]   sr;
  logic [KEY_WIDTH-1:0]   shift_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic [IDX_W-1:0]       key_idx;
  logic [KEY_WIDTH-1:0]   keys [FILE_DEPTH];

  // Pin synchronisers. cs_n resets to its inactive level, so a pin already
  // high when reset is released is not mistaken for a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      sdat_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], spi_serial};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  // Edge detection. Data is taken from the same synchroniser depth as the clock.
  always_comb begin
    sclk_s  = sclk_sync[SYNC_STAGES-1];
    sdat_s  = sdat_sync[SYNC_STAGES-1];
    cs_s    = cs_sync[SYNC_STAGES-1];
    rise    = sclk_s & ~sclk_prev;
    cs_fall = ~cs_s & cs_prev;
  end

  // Next shift-register value for the configured bit order.
  always_comb begin
    shift_next = sr;
    if (MSB_FIRST != 0) begin
      shift_next = {sr[KEY_WIDTH-2:0], sdat_s};
    end else begin
      shift_next = {sdat_s, sr[KEY_WIDTH-1:1]};
    end
  end

  // Frame control FSM. In SHIFT, a data rise has priority over cs_n going high,
  // so a final bit that arrives together with cs_n rising still commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      key_idx     <= '0;
      key_wr      <= 1'b0;
      key_wr_idx  <= '0;
      keys_ready  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      key_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= SHIFT;
            bit_cnt     <= '0;
            key_idx     <= '0;
            keys_ready  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
          end
        end
        SHIFT: begin
          if (rise) begin
            sr <= shift_next;
            if (bit_cnt == CNT_W'(KEY_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= COMMIT;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (cs_s) begin
            // The host aborted mid-key. Drop the partial key and keep the
            // keys that were already committed.
            state     <= IDLE;
            frame_err <= 1'b1;
          end
        end
        COMMIT: begin
          key_wr     <= 1'b1;
          key_wr_idx <= key_idx;
          bit_cnt    <= '0;
          if (key_idx == IDX_W'(NUM_KEYS - 1)) begin
            state      <= DONE;
            keys_ready <= 1'b1;
          end else begin
            key_idx <= key_idx + IDX_W'(1);
            state   <= SHIFT;
          end
        end
        DONE: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (rise) begin
            overrun_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Key file write. The commit lands on the same edge that raises key_wr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FILE_DEPTH; i++) begin
        keys[i] <= '0;
      end
    end else if (state == COMMIT) begin
      keys[key_idx] <= sr;
    end
  end

  // Registered read port. A read of the entry being committed returns the old
  // value in that cycle and the new value in the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_key <= '0;
    end else begin
      rd_key <= keys[rd_idx];
    end
  end

endmodule

// File: tb/tb_spi_key_loader.sv
// Bench for spi_key_loader: a default-parameter instance plus a small
// LSB-first instance. The key file is modelled as an array of committed
// values, and a queue holds the keys expected to be committed.
module tb_spi_key_loader;

  localparam int KW  = 48;
  localparam int NK  = 16;
  localparam int IW  = 4;
  localparam int SKW = 8;
  localparam int SNK = 3;
  localparam int SIW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          spi_clk, spi_serial, spi_cs_n;
  logic [IW-1:0] rd_idx;
  logic [KW-1:0] rd_key;
  logic          key_wr;
  logic [IW-1:0] key_wr_idx;
  logic          keys_ready, frame_err, overrun_err;

  logic           s_spi_clk, s_spi_serial, s_spi_cs_n;
  logic [SIW-1:0] s_rd_idx;
  logic [SKW-1:0] s_rd_key;
  logic           s_key_wr;
  logic [SIW-1:0] s_key_wr_idx;
  logic           s_keys_ready, s_frame_err, s_overrun_err;

  spi_key_loader u_dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_serial(spi_serial), .spi_cs_n(spi_cs_n),
    .rd_idx(rd_idx), .rd_key(rd_key), .key_wr(key_wr), .key_wr_idx(key_wr_idx),
    .keys_ready(keys_ready), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  spi_key_loader #(.KEY_WIDTH(SKW), .NUM_KEYS(SNK), .MSB_FIRST(0), .SYNC_STAGES(2)) u_small (
    .clk(clk), .rst(rst), .spi_clk(s_spi_clk), .spi_serial(s_spi_serial), .spi_cs_n(s_spi_cs_n),
    .rd_idx(s_rd_idx), .rd_key(s_rd_key), .key_wr(s_key_wr), .key_wr_idx(s_key_wr_idx),
    .keys_ready(s_keys_ready), .frame_err(s_frame_err), .overrun_err(s_overrun_err)
  );

  // ---------------- model / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [KW-1:0]    mkeys [NK];
  logic [IW+KW-1:0] exp_q[$];
  logic [KW-1:0]    frame_keys [NK];
  logic [KW-1:0]    prev_exp;
  int               s_wr_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare for the main instance. rd_key must equal the
  // model's key file as it stood one cycle earlier. Each key_wr must match
  // the next expected commit, and the model's file is updated from the
  // queue, not from the DUT.
  always @(negedge clk) begin
    if (rst) begin
      prev_exp = '0;
    end else begin
      check("rd_key", 64'(rd_key), 64'(prev_exp));
      if (key_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_wr actual idx=%0d required none", key_wr_idx);
        end else begin
          logic [IW+KW-1:0] e;
          e = exp_q.pop_front();
          check("key_wr_idx", 64'(key_wr_idx), 64'(e[KW +: IW]));
          check("keys_ready_at_wr", 64'(keys_ready), 64'(e[KW +: IW] == IW'(NK - 1)));
          mkeys[e[KW +: IW]] = e[KW-1:0];
        end
      end
      prev_exp = mkeys[rd_idx];
    end
  end

  // Small instance: commits must arrive in index order.
  always @(negedge clk) begin
    if (!rst && s_key_wr) begin
      check("s_key_wr_idx", 64'(s_key_wr_idx), 64'(s_wr_cnt));
      s_wr_cnt++;
    end
  end

  // Overall time bound.
  initial begin
    repeat (70000) @(posedge clk);
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [KW-1:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[KW-1:0];
  endfunction

  // One serial bit at clk/6. Data changes while spi_clk is low, then spi_clk rises.
  task automatic send_bit(input bit sel, input logic b, input bit raise_cs);
    if (!sel) begin spi_clk = 1'b0; spi_serial = b; end
    else begin s_spi_clk = 1'b0; s_spi_serial = b; end
    tick(3);
    if (!sel) begin
      spi_clk = 1'b1;
      if (raise_cs) spi_cs_n = 1'b1;
    end else begin
      s_spi_clk = 1'b1;
    end
    tick(3);
  endtask

  // Sends nbits of v in the order that makes the stored key equal v.
  task automatic send_key(input bit sel, input logic [KW-1:0] v, input int kw,
                          input bit msb_first, input int nbits, input bit raise_cs_last);
    for (int i = 0; i < nbits; i++) begin
      int pos;
      pos = msb_first ? (kw - 1 - i) : i;
      send_bit(sel, v[pos], raise_cs_last && (i == nbits - 1));
    end
  endtask

  // Full frame from frame_keys. cs_mode: 0 raise cs_n after the frame,
  // 1 raise it together with the final rise, 2 leave it low.
  task automatic send_main_frame(input int cs_mode);
    spi_cs_n = 1'b0;
    tick(8);
    for (int k = 0; k < NK; k++) begin
      exp_q.push_back({IW'(k), frame_keys[k]});
      send_key(1'b0, frame_keys[k], KW, 1'b1, KW, (cs_mode == 1) && (k == NK - 1));
    end
    if (cs_mode == 0) begin
      tick(4);
      spi_cs_n = 1'b1;
    end
    tick(10);
  endtask

  task automatic randomize_frame();
    for (int k = 0; k < NK; k++) frame_keys[k] = rand48();
  endtask

  task automatic check_flags(input string name, input logic kr, input logic fe, input logic oe);
    check({name, "_keys_ready"}, 64'(keys_ready), 64'(kr));
    check({name, "_frame_err"}, 64'(frame_err), 64'(fe));
    check({name, "_overrun_err"}, 64'(overrun_err), 64'(oe));
  endtask

  task automatic sweep_keys(input string name);
    for (int i = 0; i < NK; i++) begin
      rd_idx = IW'(i);
      tick(1);
      check(name, 64'(rd_key), 64'(mkeys[i]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [KW-1:0] k1_prior;
    logic [SKW-1:0] skeys [SNK];

    for (int i = 0; i < NK; i++) mkeys[i] = '0;
    spi_clk = 1'b0; spi_serial = 1'b0; spi_cs_n = 1'b1; rd_idx = '0;
    s_spi_clk = 1'b0; s_spi_serial = 1'b0; s_spi_cs_n = 1'b1; s_rd_idx = '0;
    rst = 1'b1;
    tick(4);
    check("reset_rd_key", 64'(rd_key), 64'h0);
    check("reset_key_wr", 64'(key_wr), 64'h0);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(4);

    // Test 1: the reference frame, MSB first.
    randomize_frame();
    frame_keys[0]  = 48'h38acef46564a;
    frame_keys[15] = 48'hd33a2d238d68;
    send_main_frame(0);
    check("t1_pending", 64'(exp_q.size()), 64'h0);
    check_flags("t1", 1'b1, 1'b0, 1'b0);
    rd_idx = 4'd0;
    tick(1);
    check("t1_key0_literal", 64'(rd_key), 64'h38acef46564a);
    rd_idx = 4'd15;
    tick(1);
    check("t1_key15_literal", 64'(rd_key), 64'hd33a2d238d68);
    sweep_keys("t1_sweep");

    // Test 2: abort in the middle of key1.
    k1_prior = mkeys[1];
    randomize_frame();
    spi_cs_n = 1'b0;
    tick(8);
    exp_q.push_back({IW'(0), frame_keys[0]});
    send_key(1'b0, frame_keys[0], KW, 1'b1, KW, 1'b0);
    send_key(1'b0, frame_keys[1], KW, 1'b1, 20, 1'b0);
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
    check_flags("t2_abort", 1'b0, 1'b1, 1'b0);
    rd_idx = 4'd1;
    tick(2);
    check("t2_key1_prior", 64'(rd_key), 64'(k1_prior));
    randomize_frame();
    send_main_frame(0);
    check_flags("t2_reload", 1'b1, 1'b0, 1'b0);
    sweep_keys("t2_sweep");

    // Test 3: extra rises after the frame while cs_n is still low.
    randomize_frame();
    send_main_frame(2);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    tick(10);
    check_flags("t3_overrun", 1'b1, 1'b0, 1'b1);
    spi_cs_n = 1'b1;
    tick(10);
    check_flags("t3_after_cs", 1'b1, 1'b0, 1'b1);
    sweep_keys("t3_sweep");

    // Test 5: asynchronous reset after 100 bits of a new frame.
    randomize_frame();
    spi_cs_n = 1'b0;
    tick(8);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({IW'(k), frame_keys[k]});
      send_key(1'b0, frame_keys[k], KW, 1'b1, KW, 1'b0);
    end
    send_key(1'b0, frame_keys[2], KW, 1'b1, 4, 1'b0);
    check("t5_pending", 64'(exp_q.size()), 64'h0);
    rd_idx = 4'd0;
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rd_key", 64'(rd_key), 64'h0);
    check("t5_key_wr_idx", 64'(key_wr_idx), 64'h0);
    check_flags("t5_reset", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NK; i++) mkeys[i] = '0;
    exp_q.delete();
    spi_clk = 1'b0; spi_cs_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    randomize_frame();
    send_main_frame(0);
    check_flags("t5_reload", 1'b1, 1'b0, 1'b0);
    sweep_keys("t5_sweep");

    // Test 6: cs_n rises in the same clk as the final data rise.
    randomize_frame();
    send_main_frame(1);
    check_flags("t6", 1'b1, 1'b0, 1'b0);
    check("t6_pending", 64'(exp_q.size()), 64'h0);
    sweep_keys("t6_sweep");

    // Test 4: small LSB-first instance. Key0 bits are 1,0,0,0,0,0,0,0.
    skeys[0] = 8'h01;
    skeys[1] = 8'($urandom_range(0, 255));
    skeys[2] = 8'($urandom_range(0, 255));
    s_spi_cs_n = 1'b0;
    tick(8);
    for (int k = 0; k < SNK; k++) send_key(1'b1, KW'(skeys[k]), SKW, 1'b0, SKW, 1'b0);
    tick(4);
    s_spi_cs_n = 1'b1;
    tick(10);
    check("t4_wr_count", 64'(s_wr_cnt), 64'd3);
    check("t4_keys_ready", 64'(s_keys_ready), 64'h1);
    check("t4_frame_err", 64'(s_frame_err), 64'h0);
    check("t4_overrun_err", 64'(s_overrun_err), 64'h0);
    s_rd_idx = 2'd0;
    tick(1);
    check("t4_key0_literal", 64'(s_rd_key), 64'h01);
    for (int k = 1; k < SNK; k++) begin
      s_rd_idx = SIW'(k);
      tick(1);
      check("t4_key", 64'(s_rd_key), 64'(skeys[k]));
    end
    s_rd_idx = 2'd3;
    tick(1);
    check("t4_out_of_range", 64'(s_rd_key), 64'h0);

    tick(4);
    check("final_pending", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
